// File: rtl/load_store_queue.sv
// In-order load/store queue: circular buffer feeding a blocking cache one op at a time,
// reissuing missed loads after MISS_PENALTY cycles. Define LSQ_PERF_EN to add miss_count.
module load_store_queue #(
    parameter int DEPTH        = 8,
    parameter int MISS_PENALTY = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic                     enq_is_store,
    input  logic                     enq_size,
    input  logic [31:0]              enq_addr,
    input  logic [31:0]              enq_data,
    input  logic [5:0]               enq_tag,
    input  logic                     flush,
    output logic                     cache_read,
    output logic                     cache_write,
    output logic                     cache_size,
    output logic [31:0]              cache_addr,
    output logic [31:0]              cache_data,
    input  logic [31:0]              cache_rdata,
    input  logic                     cache_miss,
    output logic                     ld_valid,
    output logic [5:0]               ld_tag,
    output logic [31:0]              ld_data,
`ifdef LSQ_PERF_EN
    output logic [15:0]              miss_count,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, WAIT} state_t;

    logic        ent_store [DEPTH];
    logic        ent_size  [DEPTH];
    logic [31:0] ent_addr  [DEPTH];
    logic [31:0] ent_data  [DEPTH];
    logic [5:0]  ent_tag   [DEPTH];

    state_t          state_reg, state_next;
    logic [AW-1:0]   head_reg, head_next, tail_reg, tail_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [3:0]      pen_reg, pen_next;
    logic            ld_valid_reg, ld_fire, deq, miss_evt;
    logic [5:0]      ld_tag_reg;
    logic [31:0]     ld_data_reg;
    logic            enq_fire;
    logic            head_store;

    assign enq_ready  = (count_reg < CW'(DEPTH));
    assign enq_fire   = enq_valid && enq_ready && !flush;
    assign head_store = ent_store[head_reg];

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            ent_store[tail_reg] <= enq_is_store;
            ent_size[tail_reg]  <= enq_size;
            ent_addr[tail_reg]  <= enq_addr;
            ent_data[tail_reg]  <= enq_data;
            ent_tag[tail_reg]   <= enq_tag;
        end
    end

    always_comb begin
        state_next = state_reg;
        pen_next   = pen_reg;
        deq        = 1'b0;
        ld_fire    = 1'b0;
        miss_evt   = 1'b0;
        case (state_reg)
            IDLE:  if (count_reg != '0) state_next = ISSUE;
            ISSUE: state_next = RESP;
            RESP: begin
                if (head_store) begin
                    deq        = 1'b1;
                    state_next = IDLE;
                end else if (!cache_miss) begin
                    deq        = 1'b1;
                    ld_fire    = 1'b1;
                    state_next = IDLE;
                end else begin
                    miss_evt   = 1'b1;
                    pen_next   = 4'(MISS_PENALTY);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                pen_next = pen_reg - 4'd1;
                if (pen_reg <= 4'd1) state_next = ISSUE;
            end
            default: state_next = IDLE;
        endcase
        // Squash wins over everything except a cache op already on the bus this cycle.
        if (flush) begin
            state_next = IDLE;
            pen_next   = '0;
            deq        = 1'b0;
            ld_fire    = 1'b0;
        end
    end

    assign head_next  = flush ? '0 : (deq ? head_reg + AW'(1) : head_reg);
    assign tail_next  = flush ? '0 : (enq_fire ? tail_reg + AW'(1) : tail_reg);
    assign count_next = flush ? '0 : count_reg + CW'(enq_fire) - CW'(deq);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            pen_reg      <= '0;
            ld_valid_reg <= 1'b0;
            ld_tag_reg   <= '0;
            ld_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            pen_reg      <= pen_next;
            ld_valid_reg <= ld_fire;
            if (ld_fire) begin
                ld_tag_reg  <= ent_tag[head_reg];
                ld_data_reg <= cache_rdata;
            end
        end
    end

    assign cache_read  = (state_reg == ISSUE) && !head_store;
    assign cache_write = (state_reg == ISSUE) &&  head_store;
    assign cache_size  = (state_reg == ISSUE) ? ent_size[head_reg] : 1'b0;
    assign cache_addr  = (state_reg == ISSUE) ? ent_addr[head_reg] : 32'd0;
    assign cache_data  = (state_reg == ISSUE) ? ent_data[head_reg] : 32'd0;

    assign ld_valid = ld_valid_reg;
    assign ld_tag   = ld_tag_reg;
    assign ld_data  = ld_data_reg;
    assign count    = count_reg;

`ifdef LSQ_PERF_EN
    logic [15:0] miss_count_reg;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            miss_count_reg <= '0;
        else if (miss_evt && miss_count_reg != 16'hFFFF)
            miss_count_reg <= miss_count_reg + 16'd1;
    end
    assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: a small registered cache model plus issue/return logs.
module tb_load_store_queue;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        enq_valid = 1'b0, enq_is_store = 1'b0, enq_size = 1'b0, flush = 1'b0;
    logic [31:0] enq_addr = '0, enq_data = '0;
    logic [5:0]  enq_tag = '0;
    logic        enq_ready, cache_read, cache_write, cache_size, ld_valid;
    logic [31:0] cache_addr, cache_data, ld_data;
    logic [31:0] cache_rdata = '0;
    logic        cache_miss = 1'b0;
    logic [5:0]  ld_tag;
    logic [3:0]  count;
`ifdef LSQ_PERF_EN
    logic [15:0] miss_count;
`endif

    always #5 clk = ~clk;

    load_store_queue #(.DEPTH(8), .MISS_PENALTY(4)) dut (
        .clk(clk), .rstn(rstn),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_is_store(enq_is_store),
        .enq_size(enq_size), .enq_addr(enq_addr), .enq_data(enq_data), .enq_tag(enq_tag),
        .flush(flush),
        .cache_read(cache_read), .cache_write(cache_write), .cache_size(cache_size),
        .cache_addr(cache_addr), .cache_data(cache_data),
        .cache_rdata(cache_rdata), .cache_miss(cache_miss),
        .ld_valid(ld_valid), .ld_tag(ld_tag), .ld_data(ld_data),
`ifdef LSQ_PERF_EN
        .miss_count(miss_count),
`endif
        .count(count)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return a + 32'h0000_BDEF;
    endfunction

    // Cache model: response registered on the ISSUE edge; misses come from a script.
    bit          miss_plan[$];
    logic [31:0] iss_addr[$], iss_data[$];
    bit          iss_wr[$];
    int          iss_cyc[$];
    logic [5:0]  ld_tags[$];
    logic [31:0] ld_datas[$];
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (cache_read || cache_write) begin
            cache_rdata <= rdata_of(cache_addr);
            if (cache_read && miss_plan.size() > 0) cache_miss <= miss_plan.pop_front();
            else                                    cache_miss <= 1'b0;
            iss_addr.push_back(cache_addr);
            iss_data.push_back(cache_data);
            iss_wr.push_back(cache_write);
            iss_cyc.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (rstn && ld_valid) begin
            ld_tags.push_back(ld_tag);
            ld_datas.push_back(ld_data);
        end
    end

    task automatic steps(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        iss_addr.delete(); iss_data.delete(); iss_wr.delete(); iss_cyc.delete();
        ld_tags.delete(); ld_datas.delete();
    endtask

    task automatic drive(input logic st, input logic [31:0] a, input logic [31:0] d,
                         input logic [5:0] t);
        enq_valid = 1'b1; enq_is_store = st; enq_size = 1'b0;
        enq_addr = a; enq_data = d; enq_tag = t;
    endtask

    task automatic enq(input logic st, input logic [31:0] a, input logic [31:0] d,
                       input logic [5:0] t);
        bit done = 0;
        drive(st, a, d, t);
        for (int k = 0; k < 100 && !done; k++) begin
            done = enq_ready;
            @(negedge clk);
        end
        if (!done) check("enq_timeout", 32'd1, 32'd0);
        enq_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            done = (count == 0);
        end
        if (!done) check("drain_timeout", 32'd1, 32'd0);
        steps(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        #1 rstn = 1'b0;
        #2;
        check("rst_count", 32'(count), 0);
        check("rst_ld_valid", 32'(ld_valid), 0);
        check("rst_ld_tag", 32'(ld_tag), 0);
        check("rst_ld_data", ld_data, 0);
        check("rst_cache_op", {30'd0, cache_read, cache_write}, 0);
        steps(2);
        rstn = 1'b1;
        steps(1);
        check("rst_enq_ready", 32'(enq_ready), 1);

        // Hit load latency E0..E4
        clear_logs();
        drive(1'b0, 32'h100, 32'h0, 6'd5);
        steps(1);
        enq_valid = 1'b0;
        check("hit_count_e0", 32'(count), 1);
        check("hit_idle_noread", 32'(cache_read), 0);
        steps(1);
        check("hit_issue_read", 32'(cache_read), 1);
        check("hit_issue_addr", cache_addr, 32'h100);
        steps(1);
        check("hit_resp_read_low", 32'(cache_read), 0);
        check("hit_resp_noval", 32'(ld_valid), 0);
        steps(1);
        check("hit_ld_valid", 32'(ld_valid), 1);
        check("hit_ld_tag", 32'(ld_tag), 5);
        check("hit_ld_data", ld_data, 32'h0000_BEEF);
        check("hit_count_end", 32'(count), 0);
        steps(1);
        check("hit_pulse_end", 32'(ld_valid), 0);
        check("hit_tag_hold", 32'(ld_tag), 5);

        // Miss then hit
        clear_logs();
        miss_plan.push_back(1'b1);
        enq(1'b0, 32'h200, 32'h0, 6'd9);
        wait_drain();
        check("miss_reads", iss_addr.size(), 2);
        if (iss_addr.size() == 2) begin
            check("miss_reissue_gap", iss_cyc[1] - iss_cyc[0], 6);
            check("miss_reissue_addr", iss_addr[1], 32'h200);
        end
        check("miss_ld_count", ld_tags.size(), 1);
        if (ld_tags.size() == 1) begin
            check("miss_ld_tag", 32'(ld_tags[0]), 9);
            check("miss_ld_data", ld_datas[0], 32'h0000_BFEF);
        end

        // Fill: stores offered every cycle; drain is one op per 3 cycles so full after 11
        clear_logs();
        n = 0;
        while (n < 12) begin
            drive(1'b1, 32'(4 * n), 32'(n * 32'h11), 6'(n));
            if (!enq_ready) break;
            steps(1);
            n++;
        end
        check("fill_accepted", n, 11);
        check("fill_count", 32'(count), 8);
        check("fill_ready_low", 32'(enq_ready), 0);
        steps(1);
        check("fill_blocked_hold", 32'(count), 8);
        enq_valid = 1'b0;
        wait_drain();
        check("fill_issued", iss_addr.size(), 11);
        for (int k = 0; k < iss_addr.size() && k < 11; k++) begin
            check($sformatf("fill_op%0d", k), {iss_wr[k], iss_addr[k][30:0]},
                  {1'b1, 31'(4 * k)});
            check($sformatf("fill_data%0d", k), iss_data[k], 32'(k * 32'h11));
        end
        check("fill_no_ld", ld_tags.size(), 0);

        // Wrap: alternating loads/stores cross the pointer wrap point
        clear_logs();
        for (int k = 0; k < 12; k++)
            enq(1'(k % 2), 32'h400 + 32'(4 * k), 32'h1000 + 32'(k), 6'(20 + k));
        wait_drain();
        check("wrap_issued", iss_addr.size(), 12);
        for (int k = 0; k < iss_addr.size() && k < 12; k++)
            check($sformatf("wrap_op%0d", k), {iss_wr[k], iss_addr[k][30:0]},
                  {1'(k % 2), 31'(32'h400 + 4 * k)});
        check("wrap_ld_count", ld_tags.size(), 6);
        for (int k = 0; k < ld_tags.size() && k < 6; k++) begin
            check($sformatf("wrap_ld_tag%0d", k), 32'(ld_tags[k]), 32'(20 + 2 * k));
            check($sformatf("wrap_ld_data%0d", k), ld_datas[k],
                  rdata_of(32'h400 + 32'(8 * k)));
        end

        // Flush during WAIT with three entries
        clear_logs();
        miss_plan.push_back(1'b1);
        drive(1'b0, 32'h600, 32'h0, 6'd30); steps(1);
        drive(1'b1, 32'h604, 32'h1, 6'd31); steps(1);
        drive(1'b1, 32'h608, 32'h2, 6'd32); steps(1);
        enq_valid = 1'b0;
        check("flush_pre_count", 32'(count), 3);
        steps(2);
        flush = 1'b1;
        steps(1);
        flush = 1'b0;
        check("flush_count", 32'(count), 0);
        check("flush_ready", 32'(enq_ready), 1);
        clear_logs();
        steps(8);
        check("flush_no_issue", iss_addr.size(), 0);
        check("flush_no_ld", ld_tags.size(), 0);
        drive(1'b0, 32'h700, 32'h0, 6'd33); steps(1);
        enq_valid = 1'b0;
        steps(1);
        check("flush_idle_issue", 32'(cache_read), 1);
        check("flush_idle_addr", cache_addr, 32'h700);
        wait_drain();
        check("flush_after_ld", ld_tags.size(), 1);

        // Reset in the middle of an ISSUE
        drive(1'b0, 32'h800, 32'h0, 6'd40); steps(1);
        drive(1'b1, 32'h804, 32'h0, 6'd41); steps(1);
        enq_valid = 1'b0;
        check("mrst_in_issue", 32'(cache_read), 1);
        clear_logs();
        rstn = 1'b0;
        #1;
        check("mrst_count", 32'(count), 0);
        check("mrst_cache_read", 32'(cache_read), 0);
        check("mrst_ld_tag", 32'(ld_tag), 0);
        check("mrst_ld_data", ld_data, 0);
        steps(1);
        rstn = 1'b1;
        steps(10);
        check("mrst_no_ld", ld_tags.size(), 0);
        check("mrst_no_issue", iss_addr.size(), 0);
        check("mrst_ready", 32'(enq_ready), 1);

`ifdef LSQ_PERF_EN
        clear_logs();
        repeat (3) miss_plan.push_back(1'b1);
        enq(1'b0, 32'h900, 32'h0, 6'd50);
        wait_drain();
        check("perf_miss_count", 32'(miss_count), 3);
        check("perf_ld_count", ld_tags.size(), 1);
        rstn = 1'b0;
        #1;
        check("perf_rst_clear", 32'(miss_count), 0);
        steps(1);
        rstn = 1'b1;
        steps(1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
